// File: rtl/debounce_scan_scheduler.sv
// Multi-channel debouncer: one shared compare/count datapath, round-robin scanned across channels.
// Optional sticky glitch flags are built when DEBOUNCE_GLITCH_DETECT_EN is defined.
module debounce_scan_scheduler #(
   parameter int CHANNELS = 4,
   parameter int WAITTIME = 3,
   parameter int CNT_W    = 3,
   parameter int IDX_W    = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [CHANNELS-1:0] noisysignal,
   input  logic                scan_en,
   output logic [CHANNELS-1:0] conditioned,
   output logic [CHANNELS-1:0] positiveedge,
   output logic [CHANNELS-1:0] negativeedge,
   output logic [IDX_W-1:0]    scan_idx,
   input  logic                glitch_clr,
   output logic [CHANNELS-1:0] glitch
);

   logic [CHANNELS-1:0] r_sync1;
   logic [CHANNELS-1:0] r_sync2;
   logic [CHANNELS-1:0] r_cond;
   logic [CHANNELS-1:0] r_pos;
   logic [CHANNELS-1:0] r_neg;
   logic [CNT_W-1:0]    r_count [CHANNELS];
   logic [IDX_W-1:0]    r_scanIdx;

   logic                w_svcSync;
   logic                w_svcCond;
   logic [CNT_W-1:0]    w_svcCount;
   logic                w_differ;
   logic                w_expire;
   logic                w_reject;
   logic [IDX_W-1:0]    w_nextIdx;

   // Operands of the channel currently owning the shared datapath
   always_comb begin
      w_svcSync  = r_sync2[r_scanIdx];
      w_svcCond  = r_cond[r_scanIdx];
      w_svcCount = r_count[r_scanIdx];
      w_differ   = w_svcSync != w_svcCond;
      w_expire   = w_svcCount == CNT_W'(WAITTIME - 1);
      w_reject   = scan_en && !w_differ && (w_svcCount != '0);
      w_nextIdx  = (r_scanIdx == IDX_W'(CHANNELS - 1)) ? '0 : r_scanIdx + IDX_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= noisysignal;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_scanIdx <= '0;
      end else if (scan_en) begin
         r_scanIdx <= w_nextIdx;
      end
   end

   // Edge pulses are registered alongside the conditioned bit so both move on the same edge
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cond <= '0;
         r_pos  <= '0;
         r_neg  <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            r_count[k] <= '0;
         end
      end else begin
         r_pos <= '0;
         r_neg <= '0;
         if (scan_en) begin
            if (w_differ) begin
               if (w_expire) begin
                  r_cond[r_scanIdx]  <= w_svcSync;
                  r_count[r_scanIdx] <= '0;
                  r_pos[r_scanIdx]   <= w_svcSync;
                  r_neg[r_scanIdx]   <= ~w_svcSync;
               end else begin
                  r_count[r_scanIdx] <= w_svcCount + CNT_W'(1);
               end
            end else begin
               r_count[r_scanIdx] <= '0;
            end
         end
      end
   end

   assign conditioned  = r_cond;
   assign positiveedge = r_pos;
   assign negativeedge = r_neg;
   assign scan_idx     = r_scanIdx;

`ifdef DEBOUNCE_GLITCH_DETECT_EN
   logic [CHANNELS-1:0] r_glitch;
   logic [CHANNELS-1:0] w_setMask;

   always_comb begin
      w_setMask            = '0;
      w_setMask[r_scanIdx] = w_reject;
   end

   // A set in the same cycle as a clear survives the clear
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_glitch <= '0;
      end else begin
         r_glitch <= (glitch_clr ? '0 : r_glitch) | w_setMask;
      end
   end

   assign glitch = r_glitch;
`else
   logic w_unusedGlitch;
   assign w_unusedGlitch = glitch_clr | w_reject;
   assign glitch         = '0;
`endif

endmodule

// File: tb/tb_debounce_scan_scheduler.sv
// Self-checking bench for debounce_scan_scheduler: directed table, hand sequences and random stimulus
// compared every cycle against a behavioural model of the debounce rules.
module tb_debounce_scan_scheduler;

   localparam int CHANNELS = 4;
   localparam int WAITTIME = 3;
   localparam int CNT_W    = 3;
   localparam int IDX_W    = 2;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [CHANNELS-1:0] noisysignal = '0;
   logic                scan_en = 1'b1;
   logic                glitch_clr = 1'b0;
   logic [CHANNELS-1:0] conditioned;
   logic [CHANNELS-1:0] positiveedge;
   logic [CHANNELS-1:0] negativeedge;
   logic [IDX_W-1:0]    scan_idx;
   logic [CHANNELS-1:0] glitch;

   int checks = 0;
   int failures = 0;

   debounce_scan_scheduler #(
      .CHANNELS(CHANNELS), .WAITTIME(WAITTIME), .CNT_W(CNT_W), .IDX_W(IDX_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .noisysignal(noisysignal), .scan_en(scan_en),
      .conditioned(conditioned), .positiveedge(positiveedge), .negativeedge(negativeedge),
      .scan_idx(scan_idx), .glitch_clr(glitch_clr), .glitch(glitch)
   );

   always #10 clk = ~clk;

   // Behavioural model: a channel flips after WAITTIME consecutive services that disagree
   logic [CHANNELS-1:0] mSync1, mSync2, mCond, mPos, mNeg, mGlitch;
   int                  mRun [CHANNELS];
   int                  mIdx;

   always @(posedge clk) begin
      if (!reset_n) begin
         mSync1 = '0; mSync2 = '0; mCond = '0; mPos = '0; mNeg = '0; mGlitch = '0;
         mIdx = 0;
         for (int k = 0; k < CHANNELS; k++) mRun[k] = 0;
      end else begin
         mPos = '0;
         mNeg = '0;
         if (glitch_clr) mGlitch = '0;
         if (scan_en) begin
            if (mSync2[mIdx] != mCond[mIdx]) begin
               mRun[mIdx] = mRun[mIdx] + 1;
               if (mRun[mIdx] == WAITTIME) begin
                  mCond[mIdx] = mSync2[mIdx];
                  if (mSync2[mIdx]) mPos[mIdx] = 1'b1;
                  else mNeg[mIdx] = 1'b1;
                  mRun[mIdx] = 0;
               end
            end else begin
               if (mRun[mIdx] > 0) mGlitch[mIdx] = 1'b1;
               mRun[mIdx] = 0;
            end
            mIdx = (mIdx + 1) % CHANNELS;
         end
         mSync2 = mSync1;
         mSync1 = noisysignal;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h time=%0t", name, actual, expected, $time);
      end
   endtask

   // Whole output vector compared against the model on every falling edge
   always @(negedge clk) begin
      logic [CHANNELS-1:0] expGlitch;
`ifdef DEBOUNCE_GLITCH_DETECT_EN
      expGlitch = mGlitch;
`else
      expGlitch = '0;
`endif
      checkOutput("cycle_outputs",
                  {12'd0, conditioned, positiveedge, negativeedge, glitch, 2'd0, scan_idx},
                  {12'd0, mCond, mPos, mNeg, expGlitch, 2'd0, IDX_W'(mIdx)});
   end

   task automatic applyStimulus(input logic [CHANNELS-1:0] n, input logic en, input int cycles);
      noisysignal = n;
      scan_en     = en;
      repeat (cycles) @(negedge clk);
   endtask

   typedef struct {
      logic [CHANNELS-1:0] noisy;
      logic                en;
      int                  hold;
      logic [CHANNELS-1:0] expCond;
   } vec_t;

   vec_t vecs [8];

   int posCnt [CHANNELS];
   int negTotal;
   int firstEdge;
   int pulses;
   int enEdges;
   logic [IDX_W-1:0] frozenIdx;
   int evEdge [4];
   int evChan [4];
   int evN;

   initial begin
      vecs[0] = '{4'b0000, 1'b1, 16, 4'b0000};
      vecs[1] = '{4'b0100, 1'b1, 16, 4'b0100};
      vecs[2] = '{4'b0000, 1'b1, 16, 4'b0000};
      vecs[3] = '{4'b1111, 1'b1, 16, 4'b1111};
      vecs[4] = '{4'b0101, 1'b0, 30, 4'b1111};
      vecs[5] = '{4'b0101, 1'b1, 16, 4'b0101};
      vecs[6] = '{4'b1010, 1'b1, 5,  4'b0101};
      vecs[7] = '{4'b0101, 1'b1, 16, 4'b0101};

      // Reset held with all pins high
      reset_n = 1'b0;
      applyStimulus(4'b1111, 1'b1, 3);
      checkOutput("reset_cond", {28'd0, conditioned}, 32'd0);
      checkOutput("reset_edges", {24'd0, positiveedge, negativeedge}, 32'd0);
      checkOutput("reset_idx", {30'd0, scan_idx}, 32'd0);
      reset_n = 1'b1;
      for (int k = 0; k < CHANNELS; k++) posCnt[k] = 0;
      negTotal = 0;
      for (int n = 0; n < 16; n++) begin
         @(negedge clk);
         for (int k = 0; k < CHANNELS; k++) posCnt[k] += positiveedge[k];
         negTotal += $countones(negativeedge);
      end
      checkOutput("post_reset_cond", {28'd0, conditioned}, 32'hF);
      for (int k = 0; k < CHANNELS; k++) checkOutput($sformatf("post_reset_pulses_ch%0d", k), posCnt[k], 1);
      checkOutput("post_reset_negedges", negTotal, 0);

      // Directed table
      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].noisy, vecs[v].en, vecs[v].hold);
         checkOutput($sformatf("table_vec%0d_cond", v), {28'd0, conditioned}, {28'd0, vecs[v].expCond});
      end

      // Clean step on channel 2: latency window and single pulse
      applyStimulus(4'b0000, 1'b1, 16);
      noisysignal = 4'b0100;
      firstEdge = 0;
      pulses = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (conditioned[2] && firstEdge == 0) firstEdge = n;
         pulses += positiveedge[2];
      end
      checkOutput("clean_step_latency", {31'd0, (firstEdge >= 11 && firstEdge <= 14)}, 32'd1);
      checkOutput("clean_step_pulses", pulses, 1);
      checkOutput("clean_step_others", {29'd0, conditioned[3], conditioned[1:0]}, 32'd0);

      // Bounce on channel 1 is rejected
      applyStimulus(4'b0000, 1'b1, 16);
      pulses = 0;
      firstEdge = 0;
      applyStimulus(4'b0010, 1'b1, 1);
      noisysignal = 4'b0000;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         pulses += $countones(positiveedge) + $countones(negativeedge);
         if (conditioned[1]) firstEdge = 1;
      end
      checkOutput("bounce_cond1", firstEdge, 0);
      checkOutput("bounce_pulses", pulses, 0);

      // Falling edge on channel 0 with a glitch inside the low period
      applyStimulus(4'b0001, 1'b1, 16);
      checkOutput("fall_setup_cond0", {31'd0, conditioned[0]}, 32'd1);
      negTotal = 0;
      pulses = 0;
      noisysignal = 4'b0000;
      for (int n = 0; n < 24; n++) begin
         noisysignal = (n == 3) ? 4'b0001 : 4'b0000;
         @(negedge clk);
         negTotal += negativeedge[0];
         pulses += positiveedge[0];
      end
      checkOutput("fall_negpulses", negTotal, 1);
      checkOutput("fall_pospulses", pulses, 0);
      checkOutput("fall_final_cond0", {31'd0, conditioned[0]}, 32'd0);

      // Freeze mid-count on channel 3
      applyStimulus(4'b0000, 1'b1, 16);
      noisysignal = 4'b1000;
      applyStimulus(4'b1000, 1'b1, 7);
      enEdges = 7;
      frozenIdx = scan_idx;
      applyStimulus(4'b1000, 1'b0, 20);
      checkOutput("freeze_idx", {30'd0, scan_idx}, {30'd0, frozenIdx});
      checkOutput("freeze_cond3", {31'd0, conditioned[3]}, 32'd0);
      scan_en = 1'b1;
      firstEdge = 0;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         enEdges++;
         if (conditioned[3] && firstEdge == 0) firstEdge = enEdges;
      end
      checkOutput("freeze_resume_latency", {31'd0, (firstEdge >= 11 && firstEdge <= 14)}, 32'd1);

      // All channels change together: pulses on consecutive edges in scan order
      applyStimulus(4'b0000, 1'b1, 16);
      noisysignal = 4'b1111;
      evN = 0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge clk);
         if (positiveedge != '0) begin
            checkOutput("simul_onehot", $countones(positiveedge), 1);
            if (evN < 4) begin
               evEdge[evN] = n;
               for (int k = 0; k < CHANNELS; k++) if (positiveedge[k]) evChan[evN] = k;
               evN++;
            end
         end
      end
      checkOutput("simul_events", evN, 4);
      if (evN == 4) begin
         for (int e = 1; e < 4; e++) begin
            checkOutput("simul_consecutive", evEdge[e] - evEdge[e-1], 1);
            checkOutput("simul_order", evChan[e], (evChan[e-1] + 1) % CHANNELS);
         end
      end
      checkOutput("simul_cond", {28'd0, conditioned}, 32'hF);

      // Random phase, checked by the per-cycle model comparison
      for (int n = 0; n < 3000; n++) begin
         for (int k = 0; k < CHANNELS; k++)
            if ($urandom_range(11, 0) == 0) noisysignal[k] = ~noisysignal[k];
         if ($urandom_range(15, 0) == 0) scan_en = ~scan_en;
         glitch_clr = ($urandom_range(39, 0) == 0);
         reset_n = ($urandom_range(399, 0) != 0);
         @(negedge clk);
      end
      reset_n = 1'b1;
      glitch_clr = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/debounce_scan_scheduler.md
Name: debounce_scan_scheduler

Overview:
- Multi-channel input conditioner for CHANNELS noisy pins (buttons or switches).
- One shared debounce compare/count/update datapath, time-multiplexed across channels by a round-robin scan scheduler.
- Per-channel state is limited to two sync flops, a conditioned bit and a small wait counter.
- Outputs conditioned levels plus one-cycle positive and negative edge pulses per channel to downstream FSM logic.

Parameters:
- CHANNELS, 4: number of noisy inputs; must be at least 2.
- WAITTIME, 3: consecutive service slots a channel's synchronized value must differ from its conditioned value before the conditioned value flips; must be at least 1.
- CNT_W, 3: wait counter width; must satisfy 2^CNT_W > WAITTIME.
- IDX_W, 2: scan index width; must satisfy 2^IDX_W >= CHANNELS.

Ports:
- clk  input  1  system clock, 50 MHz nominal
- reset_n  input  1  synchronous, active-low reset
- noisysignal  input  CHANNELS  raw asynchronous pins; bit k is channel k
- scan_en  input  1  1 = scheduler advances and services; 0 = freeze scan
- conditioned  output  CHANNELS  debounced, synchronized levels
- positiveedge  output  CHANNELS  one-cycle pulse when conditioned[k] rises
- negativeedge  output  CHANNELS  one-cycle pulse when conditioned[k] falls
- scan_idx  output  IDX_W  channel serviced this cycle
- glitch_clr  input  1  clears glitch flags (optional feature)
- glitch  output  CHANNELS  sticky glitch flags (optional feature)

Behaviour:
- Reset
  - Reset is sampled only on the rising edge of clk while reset_n=0. The same rule applies when reset is asserted mid-operation.
  - Reset clears all sync flops, conditioned, all counters, scan_idx, positiveedge, negativeedge and glitch to 0.
  - No edge pulse is produced in the cycle reset is released, or in the cycle after it.
- Synchronizer
  - Every channel runs a 2-flop chain (sync1, then sync2) on every cycle, independent of scan_en.
- Scheduler
  - When scan_en=1, scan_idx increments each cycle and wraps from CHANNELS-1 to 0.
  - When scan_en=0, scan_idx holds, no channel is serviced, counters and conditioned hold, and edge outputs are 0.
- Service of channel k (the cycle where scan_idx=k and scan_en=1):
  - If sync2[k] differs from conditioned[k] and count[k] equals WAITTIME-1: conditioned[k] takes sync2[k], count[k] clears to 0, and exactly one of positiveedge[k] or negativeedge[k] is asserted. The pulse is registered with conditioned, so both change on the same clock edge.
  - If they differ and count[k] is below WAITTIME-1: count[k] increments.
  - If they are equal: count[k] clears to 0.
- Non-serviced channels hold their counter and conditioned bit.
- Edge outputs stay high for exactly one cycle. At most one channel pulses per cycle.
- Latency (noisysignal change at edge 0, then held stable): conditioned changes on an edge in the range [3+(WAITTIME-1)*CHANNELS, 2+WAITTIME*CHANNELS]. With defaults this is edges 11 to 14.
- Any synchronized pulse shorter than (WAITTIME-1)*CHANNELS+1 cycles never changes conditioned.
- No saturation is needed: count never exceeds WAITTIME-1.

Optional Feature:
- Macro DEBOUNCE_GLITCH_DETECT_EN.
- Defined:
  - glitch[k] sets when a service of channel k clears a nonzero count[k], i.e. a rejected bounce.
  - glitch[k] holds until glitch_clr=1 is sampled, which clears all flags.
  - If set and clear coincide in the same cycle, set wins.
- Undefined:
  - glitch is driven constant 0 and glitch_clr is ignored.
  - Ports are present in both builds.

Test Plan (defaults, 20 ns clock, scan_en=1 unless stated):
- Reset: hold reset_n=0 for 3 cycles with noisysignal=4'b1111 -> conditioned=0, edges=0, scan_idx=0. After release, conditioned[k] rises within 14 cycles with exactly one positiveedge[k] pulse per channel.
- Clean step: noisysignal[2] goes 0 to 1 and is held 300 ns -> conditioned[2]=1 between edges 11 and 14. positiveedge[2] is high for exactly 1 cycle in that same cycle. Other channels are unaffected.
- Bounce rejection: noisysignal[1] is high for 25 ns, then 0 -> conditioned[1] stays 0 and no edge pulses occur. With DEBOUNCE_GLITCH_DETECT_EN, glitch[1] becomes 1 if a count started.
- Falling edge: after channel 0 is conditioned high, drop it with a 25 ns high glitch inside the low period, then hold low 300 ns -> exactly one negativeedge[0] pulse and final conditioned[0]=0.
- Freeze: deassert scan_en for 20 cycles mid-count on channel 3 -> scan_idx and count hold. After re-enable, conditioned[3] flips after the remaining slots only.
- Simultaneous: all 4 inputs change at once -> all four conditioned bits flip on 4 consecutive edges in scan order, with pulses never overlapping.
